// File: rtl/video_stream_sink_if.sv
// Avalon-ST video stream bundle between a pixel source and video_stream_sink.
// The slave modport is the sink's view; master is the source's view.
interface video_stream_sink_if #(
    parameter int DATA_W = 8
);
    logic              sink_valid;
    logic              sink_startofpacket;
    logic              sink_endofpacket;
    logic [DATA_W-1:0] sink_data;
    logic              sink_ready;

    modport master (
        output sink_valid,
        output sink_startofpacket,
        output sink_endofpacket,
        output sink_data,
        input  sink_ready
    );

    modport slave (
        input  sink_valid,
        input  sink_startofpacket,
        input  sink_endofpacket,
        input  sink_data,
        output sink_ready
    );
endinterface

// File: rtl/video_stream_sink.sv
// Avalon-ST video sink: writes each accepted pixel of a type-0 video packet into a
// linear frame buffer, and tracks complete frames and framing errors.
module video_stream_sink #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
) (
    input  logic                 clock,
    input  logic                 reset,
    video_stream_sink_if.slave   st,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 wr_en,
    input  logic                 wr_waitrequest,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic [15:0]          err_count
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VIDEO   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(WIDTH * HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic                frame_done_q, frame_done_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic [15:0]         err_count_q, err_count_d;
    logic                ready_s, accept_s, hdr_video_s, frame_add_s;
    logic [1:0]          err_add_s;
    logic [16:0]         err_sum_s;

    // The single write register frees up in the same cycle the buffer takes it.
    assign ready_s     = !reset && (!wr_en_q || !wr_waitrequest);
    assign accept_s    = st.sink_valid && ready_s;
    assign hdr_video_s = (st.sink_data[3:0] == 4'd0);
    assign st.sink_ready = ready_s;

    // Packet state machine and write-register next-state logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wr_en_d      = wr_en_q && wr_waitrequest;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_add_s  = 1'b0;
        err_add_s    = 2'd0;
        if (accept_s) begin
            if (st.sink_startofpacket) begin
                // A SOP inside a video packet truncates it; the SOP itself then restarts.
                err_add_s = (state_q == VIDEO) ? 2'd1 : 2'd0;
                if (st.sink_endofpacket) begin
                    state_d = IDLE;
                    if (hdr_video_s) begin
                        err_add_s = err_add_s + 2'd1;
                    end else begin
                        err_add_s = err_add_s;
                    end
                end else if (hdr_video_s) begin
                    state_d = VIDEO;
                    idx_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = DISCARD;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        err_add_s = 2'd1;
                    end
                    VIDEO: begin
                        if (idx_q < FRAME_PIX) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = idx_q;
                            wr_data_d = st.sink_data;
                            idx_d     = idx_q + IDX_ONE;
                            if (st.sink_endofpacket) begin
                                state_d = IDLE;
                                if (idx_q == LAST_IDX) begin
                                    frame_done_d = 1'b1;
                                    frame_add_s  = 1'b1;
                                end else begin
                                    err_add_s = 2'd1;
                                end
                            end else begin
                                state_d = VIDEO;
                            end
                        end else begin
                            err_add_s = 2'd1;
                            state_d   = st.sink_endofpacket ? IDLE : DISCARD;
                        end
                    end
                    DISCARD: begin
                        state_d = st.sink_endofpacket ? IDLE : DISCARD;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Frame counter wraps; error counter saturates.
    always_comb begin
        err_sum_s = {1'b0, err_count_q} + {15'd0, err_add_s};
        if (err_sum_s[16]) begin
            err_count_d = 16'hFFFF;
        end else begin
            err_count_d = err_sum_s[15:0];
        end
        frame_count_d = frame_count_q + {15'd0, frame_add_s};
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= {ADDR_W{1'b0}};
            wr_addr_q     <= {ADDR_W{1'b0}};
            wr_data_q     <= {DATA_W{1'b0}};
            wr_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
            err_count_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_en       = wr_en_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_video_stream_sink.sv
// Randomized bench for video_stream_sink on a reduced 8x4 frame, scored against a
// packet-level model of which pixels land where and how frames/errors are counted.
module tb_video_stream_sink;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int FP = W * H;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          wr_waitrequest;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic [15:0]   err_count;

    video_stream_sink_if #(.DATA_W(DW)) st ();

    video_stream_sink #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .st             (st),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_waitrequest (wr_waitrequest),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .err_count      (err_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_mode = 0;
    int cyc = 0;
    int got_addr[$], got_data[$], exp_addr[$], exp_data[$];
    int fd_seen = 0, exp_frames = 0, exp_errs = 0, ready_bad = 0;

    // Frame-buffer stall pattern: 0 none, 1 every 3rd cycle, 2 random, else always.
    initial begin
        wr_waitrequest = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            case (stall_mode)
                0:       wr_waitrequest = 1'b0;
                1:       wr_waitrequest = (cyc % 3 == 0);
                2:       wr_waitrequest = ($urandom_range(0, 3) == 0);
                default: wr_waitrequest = 1'b1;
            endcase
        end
    end

    // Monitor: records completed writes and frame_done pulses, checks ready rule.
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b0) begin
                if (wr_en === 1'b1 && wr_waitrequest === 1'b0) begin
                    got_addr.push_back(int'(wr_addr));
                    got_data.push_back(int'(wr_data));
                end
                if (frame_done === 1'b1) fd_seen++;
                if (st.sink_ready !== !(wr_en && wr_waitrequest)) ready_bad++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 right after the beat was accepted.
    task automatic send_beat(input bit sop, input bit eop, input logic [7:0] d);
        int t;
        t = 0;
        st.sink_valid = 1'b1;
        st.sink_startofpacket = sop;
        st.sink_endofpacket = eop;
        st.sink_data = d;
        @(negedge clock);
        while (st.sink_ready !== 1'b1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: sink_ready=%b, required 1 within 200 cycles", st.sink_ready);
        end
        @(posedge clock);
        #1;
        st.sink_valid = 1'b0;
    endtask

    // Sends one packet and applies the packet-level expectations.
    task automatic send_video(input logic [3:0] typ, input int n, input bit has_eop);
        logic [7:0] pix[$];
        logic [7:0] p;
        send_beat(1'b1, has_eop && (n == 0), {4'($urandom), typ});
        for (int i = 0; i < n; i++) begin
            p = 8'($urandom);
            pix.push_back(p);
            send_beat(1'b0, has_eop && (i == n - 1), p);
        end
        if (typ == 4'd0) begin
            for (int i = 0; i < n && i < FP; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back(int'(pix[i]));
            end
            if (n > FP)          exp_errs++;
            else if (!has_eop)   exp_errs++;
            else if (n == 0)     exp_errs++;
            else if (n < FP)     exp_errs++;
            else                 exp_frames++;
        end
    endtask

    task automatic drain();
        stall_mode = 0;
        repeat (5) @(posedge clock);
        #1;
    endtask

    function automatic int write_mismatches();
        int m = 0;
        if (got_addr.size() != exp_addr.size()) m++;
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            if (got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i]) m++;
        end
        return m;
    endfunction

    task automatic clear_writes();
        got_addr.delete();
        got_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        st.sink_valid = 1'b0;
        st.sink_startofpacket = 1'b0;
        st.sink_endofpacket = 1'b0;
        st.sink_data = 8'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({wr_en, frame_done, wr_addr, wr_data} !== {1'b0, 1'b0, 6'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: wr_en=%b done=%b addr=%0d data=%0d, required all 0", wr_en, frame_done, wr_addr, wr_data);
        end
        n_checks++;
        if (frame_count !== 16'd0 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: frames=%0d errs=%0d, required 0/0", frame_count, err_count);
        end
        n_checks++;
        if (st.sink_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: sink_ready=%b during reset, required 0", st.sink_ready);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (st.sink_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: sink_ready=%b, required 1", st.sink_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_scenario(input string name);
        int m;
        drain();
        m = write_mismatches();
        n_checks++;
        if (m !== 0) begin
            n_fail++;
            $display("FAIL %s_writes: %0d writes with %0d mismatches, required %0d matching writes", name, got_addr.size(), m, exp_addr.size());
        end
        n_checks++;
        if (frame_count !== 16'(exp_frames) || fd_seen !== exp_frames) begin
            n_fail++;
            $display("FAIL %s_frames: frame_count=%0d pulses=%0d, required %0d", name, frame_count, fd_seen, exp_frames);
        end
        n_checks++;
        if (err_count !== 16'(exp_errs)) begin
            n_fail++;
            $display("FAIL %s_errors: err_count=%0d, required %0d", name, err_count, exp_errs);
        end
        n_checks++;
        if (ready_bad !== 0) begin
            n_fail++;
            $display("FAIL %s_ready_rule: %0d cycles violated, required 0", name, ready_bad);
        end
        clear_writes();
    endtask

    task automatic test_good_frame();
        send_video(4'd0, FP, 1'b1);
        check_scenario("good_frame");
    endtask

    task automatic test_stall_every3();
        stall_mode = 1;
        send_video(4'd0, FP, 1'b1);
        check_scenario("stall3");
    endtask

    task automatic test_control_packet();
        send_video(4'($urandom_range(1, 15)), 3, 1'b1);
        send_video(4'd0, FP, 1'b1);
        check_scenario("control");
    endtask

    task automatic test_short_frame();
        send_video(4'd0, 10, 1'b1);
        send_video(4'd0, FP, 1'b1);
        check_scenario("short");
    endtask

    task automatic test_long_frame();
        send_video(4'd0, FP + 10, 1'b1);
        send_video(4'd0, FP + 1, 1'b1);
        check_scenario("long");
    endtask

    task automatic test_framing_errors();
        send_beat(1'b0, 1'b0, 8'h11);
        exp_errs++;
        send_beat(1'b0, 1'b1, 8'h22);
        exp_errs++;
        send_video(4'd0, 0, 1'b1);
        send_video(4'd5, 0, 1'b1);
        send_video(4'd0, 5, 1'b0);
        send_video(4'd0, FP, 1'b1);
        check_scenario("framing");
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            stall_mode = 2;
            send_video(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                       $urandom_range(0, FP + 4),
                       (k == 7) ? 1'b1 : ($urandom_range(0, 4) != 0));
        end
        send_video(4'd0, FP, 1'b1);
        check_scenario("random");
    endtask

    task automatic test_reset_midframe();
        send_video(4'd0, 3, 1'b0);
        stall_mode = 3;
        send_beat(1'b0, 1'b0, 8'hA5);
        @(posedge clock);
        #1;
        st.sink_valid = 1'b1;
        st.sink_data = 8'h5A;
        @(negedge clock);
        n_checks++;
        if (wr_en !== 1'b1 || st.sink_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_stall: wr_en=%b ready=%b, required 1/0", wr_en, st.sink_ready);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (st.sink_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset_ready: sink_ready=%b, required 0", st.sink_ready);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        st.sink_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (wr_en !== 1'b0 || frame_count !== 16'd0 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midframe_reset_state: wr_en=%b frames=%0d errs=%0d, required 0/0/0", wr_en, frame_count, err_count);
        end
        exp_frames = 0;
        exp_errs = 0;
        fd_seen = 0;
        clear_writes();
        stall_mode = 0;
        @(posedge clock);
        #1;
        send_video(4'd0, FP, 1'b1);
        check_scenario("after_reset");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_stall_every3();
        test_control_packet();
        test_short_frame();
        test_long_frame();
        test_framing_errors();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
